// File: rtl/uart_pkg.sv
// Shared types and byte constants for the UART command bridge.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_BUS   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam logic [7:0] RSP_BAD = 8'h3F;

    // Width of a counter that must reach max(a, b).
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/uart_rsp_shifter.sv
// Parallel-load, byte-serial response shift register with a valid/ready
// output handshake; the most significant byte goes out first.
module uart_rsp_shifter #(
    parameter int DATA_BYTES = 4,
    parameter int LEN_W      = $clog2(DATA_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [8*DATA_BYTES-1:0] load_data,
    input  logic [LEN_W-1:0]        load_len,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    output logic                    done
);

    localparam int DW = 8 * DATA_BYTES;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [DW-1:0]    data_r;
    logic [LEN_W-1:0] rem_r;
    logic             tx_valid_r;

    // Load, then shift one byte out per accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r     <= '0;
            rem_r      <= '0;
            tx_valid_r <= 1'b0;
        end else if (load) begin
            data_r     <= load_data;
            rem_r      <= load_len;
            tx_valid_r <= (load_len != '0);
        end else if (tx_valid_r && tx_ready) begin
            data_r     <= data_r << 8;
            rem_r      <= rem_r - LEN_ONE;
            tx_valid_r <= (rem_r != LEN_ONE);
        end else begin
            data_r     <= data_r;
            rem_r      <= rem_r;
            tx_valid_r <= tx_valid_r;
        end
    end

    assign tx_valid = tx_valid_r;
    assign tx_data  = data_r[DW-1 -: 8];
    assign done     = tx_valid_r && tx_ready && (rem_r == LEN_ONE);

endmodule

// File: rtl/uart_cmd_bridge.sv
// UART command frame parser driving a req/ack register bus.
// Optional bus-ack timeout: define UART_CMD_BRIDGE_TIMEOUT_EN.
module uart_cmd_bridge
    import uart_pkg::*;
#(
    parameter int ADDR_BYTES  = 2,
    parameter int DATA_BYTES  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [8*ADDR_BYTES-1:0] bus_addr,
    output logic [8*DATA_BYTES-1:0] bus_wdata,
    input  logic                    bus_ack,
    input  logic [8*DATA_BYTES-1:0] bus_rdata,
    output logic                    busy,
    output logic                    err_overrun
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam int CW = cnt_width(ADDR_BYTES, DATA_BYTES);
    localparam int LW = $clog2(DATA_BYTES + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);
    localparam logic [LW-1:0] LEN_ONE   = LW'(1);
    localparam logic [LW-1:0] LEN_FULL  = LW'(DATA_BYTES);

    state_t        state_r, state_next_s;
    logic [CW-1:0] cnt_r;
    logic          we_r, bus_req_r, busy_r, err_overrun_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;

    logic          cnt_inc_s, we_load_s, addr_shift_s, wdata_shift_s;
    logic          req_next_s, ovr_set_s;
    logic          sh_load_s, sh_done_s;
    logic [DW-1:0] sh_data_s;
    logic [LW-1:0] sh_len_s;

`ifdef UART_CMD_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] tmo_r;

    // Cycles spent waiting in BUS; zero in every other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_r <= '0;
        end else if (state_r != ST_BUS) begin
            tmo_r <= '0;
        end else begin
            tmo_r <= tmo_r + TW'(1);
        end
    end
`endif

    // Next-state decode and per-cycle datapath controls.
    always_comb begin
        state_next_s  = state_r;
        cnt_inc_s     = 1'b0;
        we_load_s     = 1'b0;
        addr_shift_s  = 1'b0;
        wdata_shift_s = 1'b0;
        req_next_s    = bus_req_r;
        ovr_set_s     = 1'b0;
        sh_load_s     = 1'b0;
        sh_data_s     = '0;
        sh_len_s      = '0;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid) begin
                    if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
                        we_load_s    = 1'b1;
                        state_next_s = ST_ADDR;
                    end else begin
                        sh_load_s               = 1'b1;
                        sh_data_s[DW-1 -: 8]    = RSP_BAD;
                        sh_len_s                = LEN_ONE;
                        state_next_s            = ST_RESP;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (rx_valid) begin
                    addr_shift_s = 1'b1;
                    cnt_inc_s    = 1'b1;
                    if (cnt_r == ADDR_LAST) begin
                        state_next_s = we_r ? ST_WDATA : ST_BUS;
                        req_next_s   = !we_r;
                    end else begin
                        state_next_s = ST_ADDR;
                    end
                end else begin
                    state_next_s = ST_ADDR;
                end
            end
            ST_WDATA: begin
                if (rx_valid) begin
                    wdata_shift_s = 1'b1;
                    cnt_inc_s     = 1'b1;
                    if (cnt_r == DATA_LAST) begin
                        state_next_s = ST_BUS;
                        req_next_s   = 1'b1;
                    end else begin
                        state_next_s = ST_WDATA;
                    end
                end else begin
                    state_next_s = ST_WDATA;
                end
            end
            ST_BUS: begin
                ovr_set_s = rx_valid;
                if (bus_ack) begin
                    req_next_s   = 1'b0;
                    sh_load_s    = 1'b1;
                    state_next_s = ST_RESP;
                    if (we_r) begin
                        sh_data_s[DW-1 -: 8] = RSP_OK;
                        sh_len_s             = LEN_ONE;
                    end else begin
                        sh_data_s = bus_rdata;
                        sh_len_s  = LEN_FULL;
                    end
                end
`ifdef UART_CMD_BRIDGE_TIMEOUT_EN
                else if (tmo_r == TMO_LAST) begin
                    req_next_s           = 1'b0;
                    sh_load_s            = 1'b1;
                    sh_data_s[DW-1 -: 8] = RSP_ERR;
                    sh_len_s             = LEN_ONE;
                    state_next_s         = ST_RESP;
                end
`endif
                else begin
                    state_next_s = ST_BUS;
                end
            end
            ST_RESP: begin
                ovr_set_s = rx_valid;
                if (sh_done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                req_next_s   = 1'b0;
            end
        endcase
    end

    // State, frame capture and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            we_r          <= 1'b0;
            addr_r        <= '0;
            wdata_r       <= '0;
            bus_req_r     <= 1'b0;
            busy_r        <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            bus_req_r     <= req_next_s;
            busy_r        <= (state_next_s != ST_IDLE);
            err_overrun_r <= err_overrun_r | ovr_set_s;
            if (state_next_s != state_r) begin
                cnt_r <= '0;
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (we_load_s) begin
                we_r <= (rx_data == CMD_WR);
            end else begin
                we_r <= we_r;
            end
            if (addr_shift_s) begin
                addr_r <= (addr_r << 8) | AW'(rx_data);
            end else begin
                addr_r <= addr_r;
            end
            if (wdata_shift_s) begin
                wdata_r <= (wdata_r << 8) | DW'(rx_data);
            end else begin
                wdata_r <= wdata_r;
            end
        end
    end

    uart_rsp_shifter #(
        .DATA_BYTES (DATA_BYTES),
        .LEN_W      (LW)
    ) u_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load_s),
        .load_data (sh_data_s),
        .load_len  (sh_len_s),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .done      (sh_done_s)
    );

    assign bus_req     = bus_req_r;
    assign bus_we      = we_r;
    assign bus_addr    = addr_r;
    assign bus_wdata   = wdata_r;
    assign busy        = busy_r;
    assign err_overrun = err_overrun_r;

endmodule

// File: doc/uart_cmd_bridge.md
Name: uart_cmd_bridge

Overview:
- Host-facing responder that sits behind the UART transmitter/receiver pair.
- Consumes received bytes (rx_valid/rx_data), parses read/write command frames, and issues single transactions on a simple req/ack register bus.
- Returns response bytes through the transmit handshake (tx_valid/tx_data/tx_ready).
- Turns the UART link into a debug/config access port driven by an external initiator (PC script).

Parameters:
- ADDR_BYTES, 2, address bytes per frame (bus_addr width = 8*ADDR_BYTES)
- DATA_BYTES, 4, data bytes per frame (bus_wdata/bus_rdata width = 8*DATA_BYTES)
- TIMEOUT_CYC, 1024, bus ack timeout in clk cycles (used only with the optional feature)

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous assert, active-low
- rx_valid  input  1  one-cycle pulse: received byte available
- rx_data  input  8  received byte
- tx_valid  output  1  response byte valid
- tx_data  output  8  response byte
- tx_ready  input  1  transmitter accepts byte
- bus_req  output  1  bus request, held until bus_ack
- bus_we  output  1  1 = write, 0 = read
- bus_addr  output  8*ADDR_BYTES  bus address
- bus_wdata  output  8*DATA_BYTES  write data
- bus_ack  input  1  one-cycle completion; bus_rdata valid in the same cycle
- bus_rdata  input  8*DATA_BYTES  read data
- busy  output  1  FSM not in IDLE
- err_overrun  output  1  sticky: byte dropped while bridge was busy

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE.
- Frame format: all multi-byte fields MSB first.
  - Write: 0x57 'W', ADDR_BYTES address bytes, DATA_BYTES data bytes.
  - Read: 0x52 'R', ADDR_BYTES address bytes.
- Responses:
  - Write: single byte 0x4B 'K'.
  - Read: DATA_BYTES of bus_rdata, MSB first.
  - Unknown command byte: single byte 0x3F '?', then return to IDLE.
- FSM states: IDLE, ADDR, WDATA, BUS, RESP.
- IDLE, on rx_valid:
  - 'W' or 'R': latch bus_we; go to ADDR with byte_cnt=0.
  - Any other byte: load 0x3F and go to RESP.
- ADDR: shift each rx byte into bus_addr. On byte ADDR_BYTES, go to WDATA (write) or BUS (read).
- WDATA: shift each rx byte into bus_wdata. On byte DATA_BYTES, go to BUS.
- BUS:
  - bus_req asserts the cycle after the last frame byte is captured.
  - bus_req, bus_we, bus_addr and bus_wdata stay stable until bus_ack.
  - On bus_ack: deassert bus_req the next cycle, capture bus_rdata into the response shift register, go to RESP.
- RESP:
  - tx_valid asserts the cycle after entering.
  - tx_data stays stable while tx_valid && !tx_ready.
  - Each tx_valid && tx_ready advances to the next byte; after the last byte, tx_valid drops and the FSM returns to IDLE.
- Latencies:
  - Write frame end to bus_req: 1 cycle.
  - bus_ack to first tx_valid: 1 cycle.
- Byte counter: width clog2(max(ADDR_BYTES, DATA_BYTES)+1). It resets to 0 on every state change.
- No receive backpressure: rx_valid arriving in BUS or RESP is discarded and sets err_overrun. err_overrun clears only on reset.
- rx_valid in the same cycle as the final tx handshake is still dropped; the bridge accepts only from IDLE.
- bus_ack is ignored outside BUS.
- Reset mid-frame or mid-transaction: immediate return to IDLE, bus_req and tx_valid drop with no completion. The initiator must resynchronise.

Optional Feature:
- Macro: UART_CMD_BRIDGE_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in BUS.
  - If bus_ack is not seen within TIMEOUT_CYC cycles, bus_req drops and the response is the single byte 0x45 'E' instead of 'K' or read data.
- Without the macro: BUS waits indefinitely; no counter logic is built.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum.
  - Command/response byte constants: CMD_WR=0x57, CMD_RD=0x52, RSP_OK=0x4B, RSP_ERR=0x45, RSP_BAD=0x3F.
- One natural sub-module: uart_rsp_shifter, a parallel-load, byte-serial output shift register with the valid/ready handshake used by RESP.

Test Plan:
- Write: rx 57 12 34 DE AD BE EF -> one bus_req with we=1, addr=0x1234, wdata=0xDEADBEEF; bus_ack after 3 cycles -> tx 0x4B; busy back to 0.
- Read: rx 52 00 10; bus_ack with rdata=0xCAFEF00D -> tx CA FE F0 0D in order; tx_ready held low 5 cycles mid-stream -> tx_data stable throughout.
- Unknown command: rx 0xA5 -> tx 0x3F, no bus_req; a following valid write frame completes normally.
- Overrun: inject rx byte 0x00 while bus_req is pending -> err_overrun=1, the transaction still completes, err_overrun stays 1.
- Reset mid-transaction: rst_n low during BUS -> bus_req=0, tx_valid=0, FSM IDLE immediately; the next frame works.
- Timeout (with UART_CMD_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=16): read with no bus_ack -> bus_req drops after 16 cycles, tx 0x45.
